// File: rtl/alu_pkg.sv
// Opcode constants, FSM state type and opcode classification shared by the ALU files.
// PIPELINED_ALU_MUL_EN selects whether MUL runs on the iterative multiplier or is reported illegal.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Without the multiplier, every opcode (including MUL, reported illegal) completes in one cycle.
    function automatic logic is_single_cycle(input logic [3:0] op);
`ifdef PIPELINED_ALU_MUL_EN
        return op != OP_MUL;
`else
        return (op == op);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier: start latches operands, one partial product per cycle,
// done is high on the final step with the low WIDTH bits of the product on product.
module alu_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] step_sum;

    always_comb begin
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            count_d  = CW'(WIDTH);
            mcand_d  = multiplicand;
            mplier_d = multiplier;
            acc_d    = '0;
        end else if (count_q != '0) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // The last partial product is folded in combinationally so the result lands on the final step.
    assign done    = (count_q == CW'(1));
    assign product = step_sum;

endmodule

// File: rtl/pipelined_alu.sv
// Valid/ready ALU with a registered result stage; single-cycle ops at full throughput.
// Define PIPELINED_ALU_MUL_EN to enable the WIDTH-cycle MUL path, otherwise opcode 1011 is illegal.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_control,
    input  logic [SHW-1:0]   shift_amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;
    logic             rdy_en_q;

    logic             accept, take;
    logic [WIDTH-1:0] sum, diff, alu_val;
    logic             alu_ovf, alu_ill;

    // rdy_en_q keeps in_ready low until the first clock edge after reset is released.
    assign in_ready = rdy_en_q && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_q && out_ready;

    always_comb begin
        sum     = operand1 + operand2;
        diff    = operand1 - operand2;
        alu_val = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_control)
            OP_ADD: begin
                alu_val = sum;
                alu_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_val = diff;
                alu_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND:  alu_val = operand1 & operand2;
            OP_OR:   alu_val = operand1 | operand2;
            OP_XOR:  alu_val = operand1 ^ operand2;
            OP_NOR:  alu_val = ~(operand1 | operand2);
            OP_SLT:  alu_val = WIDTH'($signed(operand1) < $signed(operand2));
            OP_SLTU: alu_val = WIDTH'(operand1 < operand2);
            OP_SLL:  alu_val = operand2 << shift_amount;
            OP_SRL:  alu_val = operand2 >> shift_amount;
            OP_SRA:  alu_val = $signed(operand2) >>> shift_amount;
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef PIPELINED_ALU_MUL_EN
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_zero_q, mul_zero_d;

    assign mul_start = accept && !is_single_cycle(alu_control);

    alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (operand1),
        .multiplier   (operand2),
        .done         (mul_done),
        .product      (mul_product)
    );
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        if (take) begin
            out_valid_d = 1'b0;
        end
        if (accept && is_single_cycle(alu_control)) begin
            out_valid_d = 1'b1;
            result_d    = alu_val;
            zero_d      = (operand1 == operand2);
            overflow_d  = alu_ovf;
            illegal_d   = alu_ill;
        end
`ifdef PIPELINED_ALU_MUL_EN
        // zero belongs to the accepted request, so hold it aside until the product is ready.
        mul_zero_d = mul_zero_q;
        if (mul_start) begin
            state_d    = MUL;
            mul_zero_d = (operand1 == operand2);
        end
        if ((state_q == MUL) && mul_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            result_d    = mul_product;
            zero_d      = mul_zero_q;
            overflow_d  = 1'b0;
            illegal_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
            mul_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            rdy_en_q    <= 1'b1;
`ifdef PIPELINED_ALU_MUL_EN
            mul_zero_q  <= mul_zero_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu: hand-computed vectors, immediate assertions per check.
// MUL expectations follow PIPELINED_ALU_MUL_EN (real product when defined, illegal otherwise).
module tb_pipelined_alu;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [3:0]       alu_control;
    logic [SHW-1:0]   shift_amount;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operand1     (operand1),
        .operand2     (operand2),
        .alu_control  (alu_control),
        .shift_amount (shift_amount),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_result   (alu_result),
        .zero         (zero),
        .overflow     (overflow),
        .illegal      (illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                           input logic ovf, input logic ill);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_result"}, 64'(alu_result), 64'(res));
        chk({tag, "_zero"}, 64'(zero), 64'(z));
        chk({tag, "_ovf"}, 64'(overflow), 64'(ovf));
        chk({tag, "_ill"}, 64'(illegal), 64'(ill));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        alu_control  = op;
        operand1     = a;
        operand2     = b;
        shift_amount = sh;
        in_valid     = 1'b1;
        $display("issue op=%b a=0x%h b=0x%h sh=%0d in_ready=%b", op, a, b, sh, in_ready);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic ok;
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        operand1     = '0;
        operand2     = '0;
        alu_control  = '0;
        shift_amount = '0;

        // Reset state and in_ready release behaviour
        #2 reset = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(alu_result), 64'(0));
        chk("rst_flags", 64'({zero, overflow, illegal}), 64'(0));
        #3 reset = 1'b1;
        #1 chk("rel_in_ready_pre_edge", 64'(in_ready), 64'(0));
        step();
        chk("rel_in_ready_post_edge", 64'(in_ready), 64'(1));

        // ADD signed overflow, one-cycle latency, then drain with result retained
        out_ready = 1'b1;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step();
        chk("drain_valid", 64'(out_valid), 64'(0));
        chk("drain_result_kept", 64'(alu_result), 64'h8000_0000);

        issue(OP_SUB, 32'd5, 32'd5, 0);
        chk_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0);
        issue(OP_SUB, 32'h8000_0000, 32'd1, 0);
        chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
        chk_out("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
        chk_out("sltu", 32'd0, 1'b0, 1'b0, 1'b0);
        issue(OP_SRA, 32'h0, 32'h8000_0000, 5'd4);
        chk_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        issue(OP_SRL, 32'h0, 32'h8000_0000, 5'd4);
        chk_out("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        issue(OP_SLL, 32'h0, 32'h0000_0001, 5'd31);
        chk_out("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
        chk_out("and", 32'h00F0_0034, 1'b0, 1'b0, 1'b0);
        issue(OP_OR, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
        chk_out("or", 32'hFFF0_12FF, 1'b0, 1'b0, 1'b0);
        issue(OP_XOR, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
        chk_out("xor", 32'hFF00_12CB, 1'b0, 1'b0, 1'b0);
        issue(OP_NOR, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
        chk_out("nor", 32'h000F_ED00, 1'b0, 1'b0, 1'b0);
        issue(4'b1100, 32'd7, 32'd7, 0);
        chk_out("illegal_op", 32'h0, 1'b1, 1'b0, 1'b1);

        // MUL: iterative product or illegal depending on build
`ifdef PIPELINED_ALU_MUL_EN
        issue(OP_MUL, 32'h0001_0003, 32'h0000_0005, 0);
        ok = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k < WIDTH; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) ok = 1'b0;
            operand1    = $urandom;
            operand2    = $urandom;
            alu_control = OP_ADD;
            step();
        end
        chk("mul_busy_window", 64'(ok), 64'(1));
        chk("mul_not_early_ready", 64'(in_ready), 64'(0));
        chk("mul_not_early_valid", 64'(out_valid), 64'(0));
        step();
        in_valid = 1'b0;
        chk_out("mul", 32'h0005_000F, 1'b0, 1'b0, 1'b0);
`else
        issue(OP_MUL, 32'h0001_0003, 32'h0000_0005, 0);
        chk_out("mul_disabled", 32'h0, 1'b0, 1'b0, 1'b1);
`endif
        step();
        chk("mul_drain", 64'(out_valid), 64'(0));

        // Back-to-back ADDs at full throughput
        in_valid    = 1'b1;
        alu_control = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            operand1 = 32'(i);
            operand2 = 32'd100;
            step();
            $display("b2b add %0d+100 -> valid=%b result=%0d", i, out_valid, alu_result);
            chk("b2b_valid", 64'(out_valid), 64'(1));
            chk("b2b_result", 64'(alu_result), 64'(i + 100));
        end
        in_valid = 1'b0;
        step();
        chk("b2b_drain", 64'(out_valid), 64'(0));

        // Output stall: result held, no new acceptance, nothing lost
        out_ready = 1'b0;
        issue(OP_ADD, 32'd10, 32'd20, 0);
        chk_out("stall_first", 32'd30, 1'b0, 1'b0, 1'b0);
        alu_control = OP_ADD;
        operand1    = 32'd1;
        operand2    = 32'd1;
        in_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            step();
            chk("stall_hold_valid", 64'(out_valid), 64'(1));
            chk("stall_hold_result", 64'(alu_result), 64'd30);
        end
        out_ready = 1'b1;
        #1 chk("stall_release_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        chk_out("stall_second", 32'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk("stall_drain", 64'(out_valid), 64'(0));

        // Reset in the middle of work
`ifdef PIPELINED_ALU_MUL_EN
        issue(OP_MUL, 32'd3, 32'd4, 0);
        repeat (9) step();
`else
        out_ready = 1'b0;
        issue(OP_ADD, 32'd4, 32'd4, 0);
        chk_out("pre_reset", 32'd8, 1'b1, 1'b0, 1'b0);
        repeat (9) step();
`endif
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_result", 64'(alu_result), 64'(0));
        chk("midrst_flags", 64'({zero, overflow, illegal}), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        step();
        #2 reset = 1'b1;
        out_ready = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            step();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("post_reset_no_result", 64'(ok), 64'(1));
        issue(OP_ADD, 32'd2, 32'd3, 0);
        chk_out("post_reset_add", 32'd5, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
